// File: rtl/a2d_sched_if.sv
// SPI command/response channel between the A2D conversion scheduler and the SPI master.
interface a2d_sched_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_sched.sv
// A2D conversion scheduler: periodic rounds over channels 0,1,3,4 with
// priority torque samples on cadence, each a two-transaction SPI exchange.
//
// state | meaning
// IDLE  | arbitrate between pending torque request and round slot
// CMD   | wrt pulse, cmd carries selected channel
// WAIT1 | wait for first transaction done (data discarded)
// GAP   | two idle cycles between transactions
// READ  | wrt pulse, same cmd, fetches the converted value
// WAIT2 | wait for done, latch value and strobe smpl_vld
module a2d_sched #(
    parameter int FAST_SIM = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cadence_rise,
    a2d_sched_if.master spi,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic [3:0]  smpl_vld,
    output logic        busy
);

    localparam int TMR_W = (FAST_SIM != 0) ? 8 : 14;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_WAIT1 = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_WAIT2 = 3'd5;

    logic [TMR_W-1:0] tmr;
    logic             tick;
    logic [2:0]       state;
    logic             gap_cnt;
    logic [1:0]       rnd_ptr;
    logic             rnd_act;
    logic             rnd_pend;
    logic             trq_pend;
    logic [2:0]       sel_ch;
    logic [2:0]       rnd_ch;
    logic             wrt_q;
    logic [15:0]      cmd_q;
    logic             unused_rd_hi;

    // Down-counter wraps through zero; terminal count at 1 puts the first
    // tick exactly one full period after reset release.
    assign tick = (tmr == TMR_W'(1));

    always_comb begin
        rnd_ch = 3'd0;
        case (rnd_ptr)
            2'd0:    rnd_ch = 3'd0;
            2'd1:    rnd_ch = 3'd1;
            2'd2:    rnd_ch = 3'd3;
            default: rnd_ch = 3'd4;
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign spi.wrt      = wrt_q;
    assign spi.cmd      = cmd_q;
    assign unused_rd_hi = ^spi.rd_data[15:12];

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr      <= '0;
            state    <= S_IDLE;
            gap_cnt  <= 1'b0;
            rnd_ptr  <= 2'd0;
            rnd_act  <= 1'b0;
            rnd_pend <= 1'b0;
            trq_pend <= 1'b0;
            sel_ch   <= 3'd0;
            wrt_q    <= 1'b0;
            cmd_q    <= 16'h0000;
            batt     <= 12'h000;
            curr     <= 12'h000;
            brake    <= 12'h000;
            torque   <= 12'h000;
            smpl_vld <= 4'b0000;
        end else begin
            tmr      <= tmr - 1'b1;
            wrt_q    <= 1'b0;
            smpl_vld <= 4'b0000;
            case (state)
                S_IDLE: begin
                    if (trq_pend) begin
                        sel_ch   <= 3'd4;
                        cmd_q    <= {2'b00, 3'd4, 11'h000};
                        trq_pend <= 1'b0;
                        wrt_q    <= 1'b1;
                        state    <= S_CMD;
                    end else if (rnd_act || rnd_pend) begin
                        sel_ch  <= rnd_ch;
                        cmd_q   <= {2'b00, rnd_ch, 11'h000};
                        // A queued round is consumed only when it actually starts.
                        if (!rnd_act) rnd_pend <= 1'b0;
                        rnd_act <= (rnd_ptr != 2'd3);
                        rnd_ptr <= rnd_ptr + 2'd1;
                        wrt_q   <= 1'b1;
                        state   <= S_CMD;
                    end
                end
                S_CMD: state <= S_WAIT1;
                S_WAIT1: begin
                    if (spi.done) begin
                        gap_cnt <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt) begin
                        wrt_q <= 1'b1;
                        state <= S_READ;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                S_READ: state <= S_WAIT2;
                S_WAIT2: begin
                    if (spi.done) begin
                        state <= S_IDLE;
                        case (sel_ch)
                            3'd0: begin batt   <= spi.rd_data[11:0]; smpl_vld <= 4'b0001; end
                            3'd1: begin curr   <= spi.rd_data[11:0]; smpl_vld <= 4'b0010; end
                            3'd3: begin brake  <= spi.rd_data[11:0]; smpl_vld <= 4'b0100; end
                            3'd4: begin torque <= spi.rd_data[11:0]; smpl_vld <= 4'b1000; end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Requests arriving on the same edge as a grant must survive it.
            if (tick)         rnd_pend <= 1'b1;
            if (cadence_rise) trq_pend <= 1'b1;
        end
    end

endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 Parameter FAST_SIM, default 0; nonzero selects the short sample interval for simulation.
REQ-002 clk  in  1  system clock; all logic is on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cadence_rise  in  1  one-cycle pulse; requests a priority torque sample.
REQ-005 done  in  1  one-cycle pulse from the SPI master; the current 16-bit transaction is complete.
REQ-006 rd_data  in  16  SPI receive word; valid in the cycle done is high.
REQ-007 wrt  out  1  one-cycle pulse; starts an SPI transaction using cmd.
REQ-008 cmd  out  16  SPI command word: {2'b00, ch[2:0], 11'h000}.
REQ-009 batt, curr, brake, torque  out  12 each  latest converted values for A2D channels 0, 1, 3 and 4.
REQ-010 smpl_vld  out  4  one-hot update strobe; bit order {torque, brake, curr, batt}.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Interval timer shall be free-running and generate a tick every 2^14 cycles (2^8 when FAST_SIM), counted from reset release.
- A tick shall set round_pend.
REQ-013 A round shall convert channels in the fixed order 0, 1, 3, 4, once each, then clear round_pend and reset the round pointer to channel 0.
REQ-014 A tick arriving during a round shall set round_pend again; at most one round is queued, and further ticks are lost.
REQ-015 cadence_rise shall set sticky flag trq_pend; it shall do so even while a torque conversion is in flight.
REQ-016 Arbitration shall occur only in IDLE.
- If trq_pend is set, select channel 4 and clear trq_pend on the wrt cycle.
- Otherwise, if a round is active or pending, select the channel at the round pointer.
- Otherwise, remain in IDLE.
REQ-017 A priority torque conversion shall not advance the round pointer; the round's own channel-4 slot is still executed.
REQ-018 FSM states shall be IDLE -> CMD -> WAIT1 -> GAP -> READ -> WAIT2 -> IDLE.
REQ-019 CMD: wrt high for exactly one cycle, and cmd loaded with the selected channel.
REQ-020 WAIT1: hold until done; rd_data is discarded.
REQ-021 GAP: exactly 2 cycles.
REQ-022 READ: wrt high for one cycle, with cmd unchanged.
REQ-023 WAIT2: hold until done.
- On done, the selected channel register shall load rd_data[11:0].
- The matching smpl_vld bit shall be high for exactly one cycle, the cycle after done, together with the register update.
- The FSM returns to IDLE.
REQ-024 done shall be ignored in IDLE, CMD, GAP and READ.
REQ-025 cmd shall hold its last value in IDLE.
- All other outputs shall hold their values except the single-cycle strobes wrt and smpl_vld.
REQ-026 Minimum conversion latency shall be 6 cycles plus the two SPI transaction times, measured from leaving IDLE to the smpl_vld pulse.
REQ-027 Unused cmd bits shall be 0; channel values shall be unsigned 12-bit, with rd_data[15:12] ignored.

Reset
REQ-028 While rst is high, the block shall set:
- state = IDLE, round pointer = channel 0;
- round_pend = 0, trq_pend = 0, timer = 0;
- wrt = 0, cmd = 0, all channel registers = 0, smpl_vld = 0, busy = 0.
REQ-029 rst asserted mid-transaction shall abort the transaction at the next edge with no register update and no smpl_vld pulse.
- Any done arriving after the abort is ignored.

Verification
REQ-030 FAST_SIM=1, SPI model returning {4'hF, ch*12'h111} with done 20 cycles after wrt.
- Response: the first tick occurs at cycle 256.
- smpl_vld pulses in the order 0001, 0010, 0100, 1000.
- batt=0x000, curr=0x111, brake=0x333, torque=0x444.
REQ-031 cadence_rise pulsed during the channel-1 conversion of a round.
- Response: the next conversion uses cmd=0x2000 (torque).
- Then the round resumes with channel 3 (cmd=0x1800), and a second torque conversion ends the round.
REQ-032 Two cadence_rise pulses during one priority torque conversion.
- Response: exactly one further torque conversion follows, not two.
REQ-033 Tick during an active round, plus a second tick before the round ends.
- Response: exactly one additional round is executed.
REQ-034 rst asserted for 1 cycle in WAIT2, with done arriving on the following cycle.
- Response: all outputs are 0 and busy=0.
- smpl_vld is never asserted, and no conversion starts until the next tick.
REQ-035 done pulsed during GAP and IDLE.
- Response: no state change and no register update.
